// File: rtl/fram_sync.sv
// Block-copy sequencer between a local synchronous-read byte buffer and an FRAM controller.
// Save issues WREN+WRITE per byte, load issues one READ per byte, each with a watchdog.
module fram_sync #(
  parameter int         DEPTH     = 64,
  parameter int         BASE_ADDR = 0,
  parameter int         TIMEOUT   = 1023,
  parameter logic [1:0] CMD_WREN  = 2'd1,
  parameter logic [1:0] CMD_WRITE = 2'd2,
  parameter logic [1:0] CMD_READ  = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_save,
  input  logic       start_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [5:0] buf_addr,
  input  logic [7:0] buf_rd_data,
  output logic       buf_wr_en,
  output logic [7:0] buf_wr_data,
  output logic [1:0] mem_cmd,
  output logic [5:0] mem_addr,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  output logic       mem_en,
  input  logic       mem_valid
);

  localparam int              WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [5:0]      BASE6    = 6'(BASE_ADDR);
  localparam logic [5:0]      LAST_IDX = 6'(DEPTH - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WREN, S_WRITE, S_READ, S_GAP, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [5:0]      idx_reg, idx_next;
  logic            phase_reg, phase_next;
  logic            save_reg, save_next;
  logic            after_wren_reg, after_wren_next;
  logic [WD_W-1:0] wd_reg, wd_next;

  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;
  logic [5:0] buf_addr_reg, buf_addr_next;
  logic       buf_wr_en_reg, buf_wr_en_next;
  logic [7:0] buf_wr_data_reg, buf_wr_data_next;
  logic [1:0] mem_cmd_reg, mem_cmd_next;
  logic [5:0] mem_addr_reg, mem_addr_next;
  logic [7:0] mem_wr_data_reg, mem_wr_data_next;
  logic       mem_en_reg, mem_en_next;

  logic [5:0] idx_inc;
  logic       in_request;

  assign idx_inc    = idx_reg + 6'd1;
  assign in_request = (state_reg == S_WREN) || (state_reg == S_WRITE) || (state_reg == S_READ);

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    phase_next       = phase_reg;
    save_next        = save_reg;
    after_wren_next  = after_wren_reg;
    wd_next          = wd_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    err_next         = 1'b0;
    buf_addr_next    = buf_addr_reg;
    buf_wr_en_next   = 1'b0;
    buf_wr_data_next = buf_wr_data_reg;
    mem_cmd_next     = mem_cmd_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wr_data_next = mem_wr_data_reg;
    mem_en_next      = mem_en_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_save) begin
          state_next    = S_FETCH;
          idx_next      = 6'd0;
          phase_next    = 1'b0;
          save_next     = 1'b1;
          busy_next     = 1'b1;
          buf_addr_next = 6'd0;
        end else if (start_load) begin
          state_next    = S_READ;
          idx_next      = 6'd0;
          save_next     = 1'b0;
          busy_next     = 1'b1;
          mem_cmd_next  = CMD_READ;
          mem_addr_next = BASE6;
          wd_next       = '0;
        end
      end

      // buf_addr was presented on entry; the buffer answers one cycle later.
      S_FETCH: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next       = 1'b0;
          mem_wr_data_next = buf_rd_data;
          mem_cmd_next     = CMD_WREN;
          mem_addr_next    = BASE6 + idx_reg;
          wd_next          = '0;
          state_next       = S_WREN;
        end
      end

      S_WREN, S_WRITE, S_READ: begin
        if (!mem_en_reg) begin
          mem_en_next = 1'b1;
        end else if (mem_valid) begin
          mem_en_next     = 1'b0;
          after_wren_next = (state_reg == S_WREN);
          state_next      = S_GAP;
          if (state_reg == S_READ) begin
            buf_wr_en_next   = 1'b1;
            buf_addr_next    = idx_reg;
            buf_wr_data_next = mem_rd_data;
          end
        end else if (wd_reg == WD_LAST) begin
          mem_en_next = 1'b0;
          err_next    = 1'b1;
          busy_next   = 1'b0;
          state_next  = S_IDLE;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end

      // Controller only re-arms on en && ~valid, so wait for valid to clear.
      S_GAP: begin
        if (!mem_valid) begin
          if (after_wren_reg) begin
            after_wren_next = 1'b0;
            mem_cmd_next    = CMD_WRITE;
            mem_addr_next   = BASE6 + idx_reg;
            wd_next         = '0;
            state_next      = S_WRITE;
          end else if (idx_reg == LAST_IDX) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_DONE;
          end else begin
            idx_next = idx_inc;
            if (save_reg) begin
              buf_addr_next = idx_inc;
              phase_next    = 1'b0;
              state_next    = S_FETCH;
            end else begin
              mem_cmd_next  = CMD_READ;
              mem_addr_next = BASE6 + idx_inc;
              wd_next       = '0;
              state_next    = S_READ;
            end
          end
        end
      end

      S_DONE: state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      idx_reg         <= 6'd0;
      phase_reg       <= 1'b0;
      save_reg        <= 1'b0;
      after_wren_reg  <= 1'b0;
      wd_reg          <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      buf_addr_reg    <= 6'd0;
      buf_wr_en_reg   <= 1'b0;
      buf_wr_data_reg <= 8'd0;
      mem_cmd_reg     <= 2'd0;
      mem_addr_reg    <= 6'd0;
      mem_wr_data_reg <= 8'd0;
      mem_en_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      phase_reg       <= phase_next;
      save_reg        <= save_next;
      after_wren_reg  <= after_wren_next;
      wd_reg          <= wd_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      buf_addr_reg    <= buf_addr_next;
      buf_wr_en_reg   <= buf_wr_en_next;
      buf_wr_data_reg <= buf_wr_data_next;
      mem_cmd_reg     <= mem_cmd_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wr_data_reg <= mem_wr_data_next;
      mem_en_reg      <= mem_en_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign buf_addr    = buf_addr_reg;
  assign buf_wr_en   = buf_wr_en_reg;
  assign buf_wr_data = buf_wr_data_reg;
  assign mem_cmd     = mem_cmd_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wr_data = mem_wr_data_reg;
  assign mem_en      = mem_en_reg;

endmodule

// File: tb/tb_fram_sync.sv
// Bench for fram_sync: behavioural buffer and FRAM controller models, a table of
// transfer scenarios, then a hand-written reset-mid-transfer sequence.
module tb_fram_sync;
  localparam int DEPTH = 4;
  localparam int BASE  = 62;
  localparam int TMO   = 15;
  localparam logic [1:0] C_WREN  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_save = 1'b0;
  logic start_load = 1'b0;
  logic busy, done, err, buf_wr_en, mem_en;
  logic [5:0] buf_addr, mem_addr;
  logic [7:0] buf_rd_data, buf_wr_data, mem_wr_data, mem_rd_data;
  logic [1:0] mem_cmd;
  logic mem_valid;

  always #5 clk = ~clk;

  fram_sync #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_load(start_load),
    .busy(busy), .done(done), .err(err),
    .buf_addr(buf_addr), .buf_rd_data(buf_rd_data), .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_en(mem_en), .mem_valid(mem_valid)
  );

  int  ctl_lat = 5;
  int  ctl_hold = 0;
  bit  ctl_dead = 1'b0;
  bit  clr = 1'b0;

  // Local buffer: synchronous read, contents restored on reset.
  logic [7:0] bufm [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) bufm[i] <= 8'h00;
      bufm[0] <= 8'h11; bufm[1] <= 8'h22; bufm[2] <= 8'h33; bufm[3] <= 8'h44;
      buf_rd_data <= 8'h00;
    end else begin
      buf_rd_data <= bufm[buf_addr];
      if (buf_wr_en) bufm[buf_addr] <= buf_wr_data;
    end
  end

  // FRAM controller model: starts on en && ~valid, holds valid until en drops (+ctl_hold).
  logic [7:0] fram [64];
  logic       act, wel;
  int         cnt, hold_cnt, ntrans;
  logic [1:0] log_cmd  [32];
  logic [5:0] log_addr [32];
  logic [7:0] log_data [32];
  always @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0; mem_rd_data <= 8'h00; act <= 1'b0; wel <= 1'b0;
      cnt <= 0; hold_cnt <= 0; ntrans <= 0;
      for (int i = 0; i < 64; i++) fram[i] <= 8'h00;
      fram[62] <= 8'hA0; fram[63] <= 8'hA1; fram[0] <= 8'hA2; fram[1] <= 8'hA3;
    end else if (clr) begin
      ntrans <= 0;
    end else begin
      if (mem_valid) begin
        if (!mem_en) begin
          if (hold_cnt >= ctl_hold) mem_valid <= 1'b0;
          else hold_cnt <= hold_cnt + 1;
        end
      end else if (act) begin
        if (!mem_en) act <= 1'b0;
        else if (!ctl_dead && cnt >= ctl_lat - 1) begin
          act <= 1'b0; mem_valid <= 1'b1; hold_cnt <= 0;
          case (mem_cmd)
            C_WREN:  wel <= 1'b1;
            C_WRITE: begin if (wel) fram[mem_addr] <= mem_wr_data; wel <= 1'b0; end
            C_READ:  mem_rd_data <= fram[mem_addr];
            default: ;
          endcase
        end else cnt <= cnt + 1;
      end else if (mem_en) begin
        act <= 1'b1; cnt <= 0;
        if (ntrans < 32) begin
          log_cmd[ntrans] <= mem_cmd; log_addr[ntrans] <= mem_addr; log_data[ntrans] <= mem_wr_data;
        end
        ntrans <= ntrans + 1;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  int ndone, nerr, en_cycles, stab_viol, rearm_viol, busy_bad, nbw;
  logic prev_en;
  logic [1:0] cap_cmd; logic [5:0] cap_addr; logic [7:0] cap_data;
  logic [5:0] bw_addr [16];
  logic [7:0] bw_data [16];
  always @(negedge clk) begin
    if (rst || clr) begin
      ndone <= 0; nerr <= 0; en_cycles <= 0; stab_viol <= 0; rearm_viol <= 0;
      busy_bad <= 0; nbw <= 0; prev_en <= 1'b0;
    end else begin
      if (done) ndone <= ndone + 1;
      if (err) nerr <= nerr + 1;
      if ((done || err) && busy) busy_bad <= busy_bad + 1;
      if (mem_en) en_cycles <= en_cycles + 1;
      if (mem_en && !prev_en) begin
        cap_cmd <= mem_cmd; cap_addr <= mem_addr; cap_data <= mem_wr_data;
        if (mem_valid) rearm_viol <= rearm_viol + 1;
      end else if (mem_en && (mem_cmd != cap_cmd || mem_addr != cap_addr || mem_wr_data != cap_data))
        stab_viol <= stab_viol + 1;
      if (buf_wr_en) begin
        if (nbw < 16) begin bw_addr[nbw] <= buf_addr; bw_data[nbw] <= buf_wr_data; end
        nbw <= nbw + 1;
      end
      prev_en <= mem_en;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, err, mem_en, mem_cmd, mem_addr, mem_wr_data,
                buf_addr, buf_wr_en, buf_wr_data});
  endfunction

  typedef struct {
    bit rst_first; bit save; bit load; bit mid_load;
    int lat; int hold; bit dead;
    int exp_ntrans; int exp_done; int exp_err; int exp_nbw;
  } vec_t;

  vec_t       vt [6];
  logic [5:0] exp_addr  [4];
  logic [7:0] exp_wdata [4];
  logic [7:0] exp_ldata [4];

  initial begin
    int c;
    exp_addr  = '{6'd62, 6'd63, 6'd0, 6'd1};
    exp_wdata = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_ldata = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    //        rst sav lod mid lat hold dead ntr dn er nbw
    vt[0] = '{1, 0, 1, 0, 5, 0, 0, 4, 1, 0, 4};   // load with wrapped addresses
    vt[1] = '{1, 1, 0, 1, 5, 0, 0, 8, 1, 0, 0};   // save, start_load pulsed mid-save
    vt[2] = '{1, 1, 0, 0, 2, 3, 0, 8, 1, 0, 0};   // save, valid held 3 cycles after en drops
    vt[3] = '{1, 1, 1, 0, 1, 0, 0, 8, 1, 0, 0};   // both starts together: save wins
    vt[4] = '{1, 0, 1, 0, 5, 0, 1, 1, 0, 1, 0};   // controller never answers
    vt[5] = '{0, 0, 1, 0, 3, 1, 0, 4, 1, 0, 4};   // load right after the timeout

    for (int s = 0; s < 6; s++) begin
      ctl_lat = vt[s].lat; ctl_hold = vt[s].hold; ctl_dead = vt[s].dead;
      if (vt[s].rst_first) begin
        rst = 1'b1; cyc(); cyc();
        chk($sformatf("s%0d_reset_outputs", s), out_vec(), 64'd0);
        rst = 1'b0;
      end
      clr = 1'b1; cyc(); clr = 1'b0;
      start_save = vt[s].save; start_load = vt[s].load; cyc();
      start_save = 1'b0; start_load = 1'b0;
      chk($sformatf("s%0d_busy_rise", s), 64'(busy), 64'd1);
      for (c = 0; c < 3000; c++) begin
        if (done || err) break;
        start_load = (vt[s].mid_load && c == 10);
        cyc();
      end
      start_load = 1'b0;
      chk($sformatf("s%0d_finished_in_time", s), 64'(c < 3000), 64'd1);
      chk($sformatf("s%0d_busy_at_end", s), 64'(busy), 64'd0);
      cyc(); cyc(); cyc(); cyc(); cyc();
      chk($sformatf("s%0d_ntrans", s), 64'(ntrans), 64'(vt[s].exp_ntrans));
      chk($sformatf("s%0d_done_pulses", s), 64'(ndone), 64'(vt[s].exp_done));
      chk($sformatf("s%0d_err_pulses", s), 64'(nerr), 64'(vt[s].exp_err));
      chk($sformatf("s%0d_buf_writes", s), 64'(nbw), 64'(vt[s].exp_nbw));
      chk($sformatf("s%0d_busy_with_pulse", s), 64'(busy_bad), 64'd0);
      chk($sformatf("s%0d_cmd_stability", s), 64'(stab_viol), 64'd0);
      chk($sformatf("s%0d_en_while_valid", s), 64'(rearm_viol), 64'd0);
      if (vt[s].dead)
        chk($sformatf("s%0d_timeout_en_cycles", s), 64'(en_cycles), 64'(TMO));
      if (vt[s].save && !vt[s].dead) begin
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("s%0d_cmd%0d", s, k), 64'(log_cmd[k]), 64'((k % 2 == 0) ? C_WREN : C_WRITE));
          if (k % 2 == 1) begin
            chk($sformatf("s%0d_waddr%0d", s, k / 2), 64'(log_addr[k]), 64'(exp_addr[k / 2]));
            chk($sformatf("s%0d_wdata%0d", s, k / 2), 64'(log_data[k]), 64'(exp_wdata[k / 2]));
          end
        end
        for (int j = 0; j < 4; j++)
          chk($sformatf("s%0d_fram%0d", s, j), 64'(fram[exp_addr[j]]), 64'(exp_wdata[j]));
      end
      if (vt[s].load && !vt[s].save && !vt[s].dead) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("s%0d_rcmd%0d", s, k), 64'(log_cmd[k]), 64'(C_READ));
          chk($sformatf("s%0d_raddr%0d", s, k), 64'(log_addr[k]), 64'(exp_addr[k]));
          chk($sformatf("s%0d_bwaddr%0d", s, k), 64'(bw_addr[k]), 64'(k));
          chk($sformatf("s%0d_bwdata%0d", s, k), 64'(bw_data[k]), 64'(exp_ldata[k]));
        end
      end
      $display("scenario %0d: save=%0b load=%0b trans=%0d done=%0d err=%0d bufwr=%0d",
               s, vt[s].save, vt[s].load, ntrans, ndone, nerr, nbw);
    end

    // Reset asserted during the third WRITE, then a fresh save from idx 0.
    ctl_lat = 5; ctl_hold = 0; ctl_dead = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    clr = 1'b1; cyc(); clr = 1'b0;
    start_save = 1'b1; cyc(); start_save = 1'b0;
    for (c = 0; c < 500; c++) begin
      if (ntrans == 6 && mem_en) break;
      cyc();
    end
    chk("rst_mid_reached_third_write", 64'({mem_en, mem_cmd}), 64'({1'b1, C_WRITE}));
    rst = 1'b1; cyc();
    chk("rst_mid_outputs", out_vec(), 64'd0);
    rst = 1'b0; cyc();
    chk("rst_mid_no_pulse", 64'({done, err, busy}), 64'd0);
    start_save = 1'b1; cyc(); start_save = 1'b0;
    for (c = 0; c < 3000; c++) begin
      if (done || err) break;
      cyc();
    end
    chk("restart_finished_in_time", 64'(c < 3000), 64'd1);
    cyc(); cyc(); cyc();
    chk("restart_ntrans", 64'(ntrans), 64'd8);
    chk("restart_done", 64'(ndone), 64'd1);
    chk("restart_first_write_addr", 64'(log_addr[1]), 64'(exp_addr[0]));
    for (int j = 0; j < 4; j++)
      chk($sformatf("restart_fram%0d", j), 64'(fram[exp_addr[j]]), 64'(exp_wdata[j]));
    $display("restart save: trans=%0d done=%0d err=%0d", ntrans, ndone, nerr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
